// File: rtl/accelerator_core_stream_gen_if.sv
// Stream bus between the weight/data generator and the accelerator core.
// Names follow the core's view: i_* flow into the core, o_data_req flows out of it.
interface accelerator_core_stream_gen_if #(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned NUM_CHANNEL = 3,
    parameter int unsigned NUM_KERNEL  = 4
);
    localparam int unsigned DATA_W   = BIT_WIDTH * NUM_CHANNEL;
    localparam int unsigned WEIGHT_W = BIT_WIDTH * NUM_CHANNEL * NUM_KERNEL;

    logic                o_data_req;
    logic [DATA_W-1:0]   i_data;
    logic                i_data_val;
    logic [WEIGHT_W-1:0] i_weight;
    logic                i_weight_val;

    modport master (
        input  o_data_req,
        output i_data,
        output i_data_val,
        output i_weight,
        output i_weight_val
    );

    modport slave (
        output o_data_req,
        input  i_data,
        input  i_data_val,
        input  i_weight,
        input  i_weight_val
    );
endinterface

// File: rtl/accelerator_core_stream_gen.sv
// Parametrised weight/data stream generator: a burst of weight beats, then one
// data beat per core request, using increment, constant or LFSR patterns.
module accelerator_core_stream_gen #(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned NUM_CHANNEL = 3,
    parameter int unsigned NUM_KERNEL  = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [1:0]           i_mode,
    input  logic [15:0]          i_seed,
    input  logic [CNT_WIDTH-1:0] i_num_weight,
    input  logic [CNT_WIDTH-1:0] i_num_data,
    accelerator_core_stream_gen_if.master bus,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int unsigned D_LANES  = NUM_CHANNEL;
    localparam int unsigned W_LANES  = NUM_CHANNEL * NUM_KERNEL;
    localparam int unsigned DATA_W   = BIT_WIDTH * D_LANES;
    localparam int unsigned WEIGHT_W = BIT_WIDTH * W_LANES;

    typedef enum logic [1:0] {IDLE, WEIGHT, DATA, DONE} state_t;

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [BIT_WIDTH-1:0]   const_q;
    logic [15:0]            lfsr_q;
    logic [CNT_WIDTH-1:0]   num_w_q;
    logic [CNT_WIDTH-1:0]   num_d_q;
    logic [CNT_WIDTH-1:0]   cnt_q;

    logic                   in_idle;
    logic [1:0]             eff_mode;
    logic [BIT_WIDTH-1:0]   eff_const;
    logic [15:0]            eff_lfsr;
    logic [CNT_WIDTH-1:0]   eff_n;
    logic [WEIGHT_W-1:0]    weight_c;
    logic [DATA_W-1:0]      data_c;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [BIT_WIDTH-1:0] lane_val(
        input logic [1:0]           mode,
        input logic [BIT_WIDTH-1:0] cval,
        input logic [BIT_WIDTH-1:0] lbits,
        input logic [31:0]          lane,
        input logic [31:0]          inc
    );
        case (mode)
            2'd1:    return cval;
            2'd2:    return lbits ^ BIT_WIDTH'(lane);
            default: return BIT_WIDTH'(inc);
        endcase
    endfunction

    // In IDLE the beat generators look at the live config so the first weight
    // beat can be registered on the start edge itself.
    always_comb begin
        in_idle   = (state_q == IDLE);
        eff_mode  = in_idle ? i_mode : mode_q;
        eff_const = in_idle ? i_seed[BIT_WIDTH-1:0] : const_q;
        eff_lfsr  = in_idle ? ((i_seed == 16'h0000) ? 16'h0001 : i_seed) : lfsr_q;
        eff_n     = in_idle ? '0 : cnt_q;
    end

    always_comb begin
        weight_c = '0;
        data_c   = '0;
        for (int unsigned j = 0; j < W_LANES; j++) begin
            weight_c[j*BIT_WIDTH +: BIT_WIDTH] = lane_val(eff_mode, eff_const,
                eff_lfsr[BIT_WIDTH-1:0], 32'(j), 32'(eff_n) * W_LANES + 32'(j));
        end
        for (int unsigned c = 0; c < D_LANES; c++) begin
            data_c[c*BIT_WIDTH +: BIT_WIDTH] = lane_val(eff_mode, eff_const,
                eff_lfsr[BIT_WIDTH-1:0], 32'(c), 32'(eff_n) * D_LANES + 32'(c));
        end
    end

    // DATA with cnt_q == num_d_q means every beat is out; DONE follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            mode_q           <= '0;
            const_q          <= '0;
            lfsr_q           <= 16'h0001;
            num_w_q          <= '0;
            num_d_q          <= '0;
            cnt_q            <= '0;
            bus.i_data       <= '0;
            bus.i_data_val   <= 1'b0;
            bus.i_weight     <= '0;
            bus.i_weight_val <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            bus.i_data_val   <= 1'b0;
            bus.i_weight_val <= 1'b0;
            o_done           <= 1'b0;
            if (!in_idle && i_stop) begin
                state_q <= IDLE;
                o_busy  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start && !i_stop) begin
                            mode_q  <= i_mode;
                            const_q <= i_seed[BIT_WIDTH-1:0];
                            num_w_q <= i_num_weight;
                            num_d_q <= i_num_data;
                            o_busy  <= 1'b1;
                            if (i_num_weight != '0) begin
                                bus.i_weight     <= weight_c;
                                bus.i_weight_val <= 1'b1;
                                lfsr_q           <= lfsr_step(eff_lfsr);
                                if (i_num_weight == CNT_WIDTH'(1)) begin
                                    state_q <= DATA;
                                    cnt_q   <= '0;
                                end else begin
                                    state_q <= WEIGHT;
                                    cnt_q   <= CNT_WIDTH'(1);
                                end
                            end else begin
                                lfsr_q <= eff_lfsr;
                                cnt_q  <= '0;
                                if (i_num_data != '0) begin
                                    state_q <= DATA;
                                end else begin
                                    state_q <= DONE;
                                    o_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    WEIGHT: begin
                        bus.i_weight     <= weight_c;
                        bus.i_weight_val <= 1'b1;
                        lfsr_q           <= lfsr_step(lfsr_q);
                        if (cnt_q == num_w_q - CNT_WIDTH'(1)) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_q == num_d_q) begin
                            state_q <= DONE;
                            o_done  <= 1'b1;
                        end else if (bus.o_data_req) begin
                            bus.i_data     <= data_c;
                            bus.i_data_val <= 1'b1;
                            lfsr_q         <= lfsr_step(lfsr_q);
                            cnt_q          <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
